fp_add_pipe: RTL



---
 rtl/fp_add_pipe.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with RNE rounding, subnormals and exception flags.
// A global stall freezes every stage while the output is held.
module fp_add_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] input_a,
  input  logic [W-1:0] input_b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] add_out,
  output logic         flag_invalid,
  output logic         flag_overflow,
  output logic         flag_inexact
);

  localparam int unsigned SW = MAN_W + 1;      // significand incl. hidden bit
  localparam int unsigned XW = MAN_W + 4;      // significand plus guard/round/sticky
  localparam int unsigned EW = EXP_W + 1;      // exponent with headroom for overflow
  localparam int unsigned PW = EW + MAN_W;     // packed exponent:fraction for rounding
  localparam int          SH_MAX = int'(MAN_W) + 3;

  localparam logic [EXP_W-1:0] ExpOnes = {EXP_W{1'b1}};
  localparam logic [W-1:0] QNaN = {1'b0, ExpOnes, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------- S1: unpack, specials, swap ----------------
  logic             a_sign, b_sign, a_big, a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0] a_exp, b_exp, a_exp_e, b_exp_e;
  logic [SW-1:0]    a_sig, b_sig;
  logic             s1_spec_d, s1_inv_d;
  logic [W-1:0]     s1_spec_res_d;

  always_comb begin
    a_sign  = input_a[W-1];
    b_sign  = input_b[W-1] ^ op_sub;
    a_exp   = input_a[W-2:MAN_W];
    b_exp   = input_b[W-2:MAN_W];
    a_exp_e = (a_exp == '0) ? EXP_W'(1) : a_exp;
    b_exp_e = (b_exp == '0) ? EXP_W'(1) : b_exp;
    a_sig   = {a_exp != '0, input_a[MAN_W-1:0]};
    b_sig   = {b_exp != '0, input_b[MAN_W-1:0]};
    a_nan   = (a_exp == ExpOnes) && (input_a[MAN_W-1:0] != '0);
    b_nan   = (b_exp == ExpOnes) && (input_b[MAN_W-1:0] != '0);
    a_inf   = (a_exp == ExpOnes) && (input_a[MAN_W-1:0] == '0);
    b_inf   = (b_exp == ExpOnes) && (input_b[MAN_W-1:0] == '0);
    a_big   = input_a[W-2:0] >= input_b[W-2:0];

    s1_inv_d      = a_nan | b_nan | (a_inf & b_inf & (a_sign != b_sign));
    s1_spec_d     = s1_inv_d | a_inf | b_inf;
    s1_spec_res_d = QNaN;
    if (!s1_inv_d) begin
      if (a_inf) s1_spec_res_d = {a_sign, ExpOnes, {MAN_W{1'b0}}};
      else       s1_spec_res_d = {b_sign, ExpOnes, {MAN_W{1'b0}}};
    end
  end

  logic             s1_valid_q, s1_spec_q, s1_inv_q, s1_sign_q, s1_sub_q;
  logic [W-1:0]     s1_spec_res_q;
  logic [EXP_W-1:0] s1_exp_q, s1_diff_q;
  logic [SW-1:0]    s1_sig_big_q, s1_sig_small_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_spec_q      <= 1'b0;
      s1_inv_q       <= 1'b0;
      s1_sign_q      <= 1'b0;
      s1_sub_q       <= 1'b0;
      s1_spec_res_q  <= '0;
      s1_exp_q       <= '0;
      s1_diff_q      <= '0;
      s1_sig_big_q   <= '0;
      s1_sig_small_q <= '0;
    end else if (!stall) begin
      s1_valid_q     <= in_valid;
      s1_spec_q      <= s1_spec_d;
      s1_inv_q       <= s1_inv_d;
      s1_spec_res_q  <= s1_spec_res_d;
      s1_sub_q       <= a_sign ^ b_sign;
      s1_sign_q      <= a_big ? a_sign : b_sign;
      s1_exp_q       <= a_big ? a_exp_e : b_exp_e;
      s1_diff_q      <= a_big ? (a_exp_e - b_exp_e) : (b_exp_e - a_exp_e);
      s1_sig_big_q   <= a_big ? a_sig : b_sig;
      s1_sig_small_q <= a_big ? b_sig : a_sig;
    end
  end

  // ---------------- S2: align and add ----------------
  int unsigned   shamt;
  logic [XW-1:0] small_ext, big_ext, shifted, sticky_mask, aligned;
  logic          sticky;
  logic [XW:0]   s2_sum_d;

  always_comb begin
    shamt       = (int'(s1_diff_q) > SH_MAX) ? SH_MAX : int'(s1_diff_q);
    small_ext   = {s1_sig_small_q, 3'b000};
    big_ext     = {s1_sig_big_q, 3'b000};
    shifted     = small_ext >> shamt;
    sticky_mask = ~({XW{1'b1}} << shamt);
    sticky      = |(small_ext & sticky_mask);
    aligned     = {shifted[XW-1:1], shifted[0] | sticky};
    // Magnitude swap guarantees big >= small, so the difference never wraps.
    s2_sum_d    = s1_sub_q ? ({1'b0, big_ext} - {1'b0, aligned})
                           : ({1'b0, big_ext} + {1'b0, aligned});
  end

  logic             s2_valid_q, s2_spec_q, s2_inv_q, s2_sign_q, s2_sub_q;
  logic [W-1:0]     s2_spec_res_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [XW:0]      s2_sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q    <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_inv_q      <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_sub_q      <= 1'b0;
      s2_spec_res_q <= '0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
    end else if (!stall) begin
      s2_valid_q    <= s1_valid_q;
      s2_spec_q     <= s1_spec_q;
      s2_inv_q      <= s1_inv_q;
      s2_sign_q     <= s1_sign_q;
      s2_sub_q      <= s1_sub_q;
      s2_spec_res_q <= s1_spec_res_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= s2_sum_d;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  function automatic int lzc(input logic [XW-1:0] v);
    int n;
    n = int'(XW);
    for (int i = 0; i < int'(XW); i++) begin
      if (v[i]) n = int'(XW) - 1 - i;
    end
    return n;
  endfunction

  int            lz, lim, sh;
  logic [XW-1:0] norm;
  logic [EW-1:0] exp_n, exp_field;
  logic [PW-1:0] packed_val, rounded;
  logic          rnd, inexact, ovf, sign_r;
  logic [W-1:0]  res_d;
  logic          inv_d, ovf_d, inx_d;

  always_comb begin
    lz    = lzc(s2_sum_q[XW-1:0]);
    lim   = int'({1'b0, s2_exp_q}) - 1;
    sh    = 0;
    norm  = '0;
    exp_n = '0;
    if (s2_sum_q[XW]) begin
      norm  = {s2_sum_q[XW:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = {1'b0, s2_exp_q} + EW'(1);
    end else begin
      // Stop at exponent 1; an unnormalised result there is a subnormal.
      sh    = (lz < lim) ? lz : lim;
      norm  = s2_sum_q[XW-1:0] << sh;
      exp_n = {1'b0, s2_exp_q} - EW'(sh);
    end
    exp_field  = norm[XW-1] ? exp_n : '0;
    packed_val = {exp_field, norm[XW-2:3]};
    rnd        = norm[2] & (norm[1] | norm[0] | norm[3]);
    inexact    = |norm[2:0];
    // Fraction carry ripples straight into the exponent field.
    rounded    = packed_val + PW'(rnd);
    ovf        = rounded[PW-1:MAN_W] >= {1'b0, ExpOnes};
    sign_r     = (s2_sum_q == '0 && s2_sub_q) ? 1'b0 : s2_sign_q;

    res_d = {sign_r, rounded[EXP_W+MAN_W-1:0]};
    inv_d = 1'b0;
    ovf_d = 1'b0;
    inx_d = inexact;
    if (s2_spec_q) begin
      res_d = s2_spec_res_q;
      inv_d = s2_inv_q;
      inx_d = 1'b0;
    end else if (ovf) begin
      res_d = {sign_r, ExpOnes, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      add_out       <= '0;
      flag_invalid  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_inexact  <= 1'b0;
    end else if (!stall) begin
      out_valid     <= s2_valid_q;
      add_out       <= res_d;
      flag_invalid  <= inv_d;
      flag_overflow <= ovf_d;
      flag_inexact  <= inx_d;
    end
  end

endmodule
